// File: rtl/simd_matmul_top.sv
// SIMD matrix engine: C = A x B^T over 8x8 unsigned 32-bit matrices held in
// 128-bit-wide RAMs; one A/B word pair is read and reduced per cycle.
module simd_ram #(
    parameter int W     = 128,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

module simd_matmul_top #(
    parameter int DW         = 32,
    parameter int LANES      = 4,
    parameter int N          = 8,
    parameter int INST_DEPTH = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    output logic stop
);
    localparam int WORDS = N * N / LANES;
    localparam int WAW   = $clog2(WORDS);
    localparam int IAW   = $clog2(INST_DEPTH);
    localparam int RW    = DW * LANES;

    // Handshake: valid is a start request, accepted only in IDLE; stop is a
    // level that rises when the run completes and drops on the next acceptance.
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state, state_next;
    logic [6:0]  idx;
    logic        drain_cnt;

    logic [RW-1:0]  a_rd, b_rd;
    logic [WAW-1:0] a_raddr, b_raddr;
    logic           s1_valid, s1_h;
    logic [2:0]     s1_i, s1_j;
    logic [DW-1:0]  lane_sum, partial, c_val;
    logic [DW-1:0]  row_buf [LANES];
    logic [DW-1:0]  wr_row  [LANES];
    logic           res_we;
    logic [WAW-1:0] res_waddr;
    logic [RW-1:0]  res_wdata;
    logic [DW-1:0]  inst_rd;

    assign a_raddr = {idx[6:4], idx[0]};
    assign b_raddr = {idx[3:1], idx[0]};

    simd_ram #(.W(RW), .DEPTH(WORDS), .AW(WAW)) ram_a (
        .clk(clk), .we(1'b0), .waddr('0), .wdata('0), .raddr(a_raddr), .rdata(a_rd));
    simd_ram #(.W(RW), .DEPTH(WORDS), .AW(WAW)) ram_b (
        .clk(clk), .we(1'b0), .waddr('0), .wdata('0), .raddr(b_raddr), .rdata(b_rd));
    simd_ram #(.W(DW), .DEPTH(INST_DEPTH), .AW(IAW)) ram_inst (
        .clk(clk), .we(1'b0), .waddr('0), .wdata('0), .raddr('0), .rdata(inst_rd));
    simd_ram #(.W(RW), .DEPTH(WORDS), .AW(WAW)) ram_result (
        .clk(clk), .we(res_we), .waddr(res_waddr), .wdata(res_wdata),
        .raddr('0), .rdata());

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid) state_next = RUN;
            RUN:     if (idx == 7'd127) state_next = DRAIN;
            DRAIN:   if (drain_cnt) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            drain_cnt <= 1'b0;
            stop      <= 1'b0;
        end else begin
            if (state == IDLE && valid) idx <= '0;
            else if (state == RUN)      idx <= idx + 7'd1;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (state == IDLE && valid) stop <= 1'b0;
            else if (state == DONE)     stop <= 1'b1;
        end
    end

    // Stage-1 tags travel alongside the 1-cycle RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_h     <= 1'b0;
            s1_i     <= '0;
            s1_j     <= '0;
        end else begin
            s1_valid <= (state == RUN);
            s1_h     <= idx[0];
            s1_i     <= idx[6:4];
            s1_j     <= idx[3:1];
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++)
            lane_sum = lane_sum + a_rd[l*DW +: DW] * b_rd[l*DW +: DW];
        c_val = partial + lane_sum;
        for (int l = 0; l < LANES; l++)
            wr_row[l] = row_buf[l];
        wr_row[s1_j[1:0]] = c_val;
        res_we    = s1_valid && s1_h && (s1_j[1:0] == 2'd3);
        res_waddr = {s1_i, s1_j[2]};
        res_wdata = '0;
        for (int l = 0; l < LANES; l++)
            res_wdata[(LANES-1-l)*DW +: DW] = wr_row[l];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            partial <= '0;
            for (int l = 0; l < LANES; l++) row_buf[l] <= '0;
        end else if (s1_valid) begin
            if (!s1_h) partial <= lane_sum;
            else       row_buf[s1_j[1:0]] <= c_val;
        end
    end
endmodule

// File: tb/tb_simd_matmul_top.sv
// Directed bench for simd_matmul_top: loads A/B hierarchically, runs the
// engine and compares every result word and the stop timing.
module tb_simd_matmul_top;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid = 1'b0;
    logic stop;

    int n_vec = 0;
    int n_miscompare = 0;

    logic [31:0] a_m [8][8];
    logic [31:0] b_m [8][8];
    logic [127:0] exp_q [$];

    simd_matmul_top dut (.clk(clk), .rst(rst), .valid(valid), .stop(stop));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_mats();
        logic [127:0] wa, wb;
        for (int r = 0; r < 8; r++)
            for (int h = 0; h < 2; h++) begin
                wa = '0; wb = '0;
                for (int e = 0; e < 4; e++) begin
                    wa[32*e +: 32] = a_m[r][4*h+e];
                    wb[32*e +: 32] = b_m[r][4*h+e];
                end
                dut.ram_a.mem[2*r+h] = wa;
                dut.ram_b.mem[2*r+h] = wb;
            end
        for (int w = 0; w < 16; w++) dut.ram_result.mem[w] = {4{32'hdeadbeef}};
    endtask

    task automatic build_expected();
        logic [31:0] c [8][8];
        logic [127:0] w;
        exp_q.delete();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                c[i][j] = '0;
                for (int k = 0; k < 8; k++) c[i][j] = c[i][j] + a_m[i][k] * b_m[j][k];
            end
        for (int i = 0; i < 8; i++)
            for (int h = 0; h < 2; h++) begin
                w = {c[i][4*h], c[i][4*h+1], c[i][4*h+2], c[i][4*h+3]};
                exp_q.push_back(w);
            end
    endtask

    task automatic compare_results(input string tag);
        logic [127:0] e;
        for (int w = 0; w < 16; w++) begin
            e = exp_q.pop_front();
            check($sformatf("%s_w%0d", tag, w), dut.ram_result.mem[w], e);
        end
    endtask

    // Pulses valid, optionally re-pulses it at edge busy_at, and counts edges to stop.
    task automatic run_engine(input string tag, input int busy_at, input bit check_lat);
        int cnt;
        @(negedge clk) valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        check({tag, "_stop_clr"}, {127'b0, stop}, 128'd0);
        cnt = 0;
        while (cnt < 400) begin
            @(posedge clk);
            cnt++;
            #1;
            valid = (cnt == busy_at);
            if (stop) break;
        end
        valid = 1'b0;
        if (check_lat) check({tag, "_latency"}, 128'(cnt), 128'd131);
        else if (!stop) check({tag, "_timeout"}, {127'b0, stop}, 128'd1);
    endtask

    initial begin
        bit seen;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_stop", {127'b0, stop}, 128'd0);
        check("rst_state", 128'(dut.state), 128'd0);
        seen = 0;
        repeat (500) begin
            @(posedge clk);
            #1 if (stop) seen = 1;
        end
        check("idle_no_stop", {127'b0, seen}, 128'd0);

        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                a_m[i][k] = (i == k) ? 32'd1 : 32'd0;
                b_m[i][k] = (i == k) ? 32'd1 : 32'd0;
            end
        load_mats();
        run_engine("ident", 0, 1);
        check("ident_w0", dut.ram_result.mem[0], 128'h00000001_00000000_00000000_00000000);
        check("ident_w1", dut.ram_result.mem[1], 128'd0);
        build_expected();
        compare_results("ident");

        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                a_m[i][k] = 32'hffffffff;
                b_m[i][k] = 32'hffffffff;
            end
        load_mats();
        run_engine("wrap", 0, 1);
        for (int w = 0; w < 16; w++)
            check($sformatf("wrap_w%0d", w), dut.ram_result.mem[w], {4{32'h00000008}});

        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                a_m[i][k] = 32'd1;
                b_m[i][k] = 32'(i + 1);
            end
        load_mats();
        run_engine("layout", 0, 1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("layout_r%0d_lo", i), dut.ram_result.mem[2*i],
                  {32'd8, 32'd16, 32'd24, 32'd32});
            check($sformatf("layout_r%0d_hi", i), dut.ram_result.mem[2*i+1],
                  {32'd40, 32'd48, 32'd56, 32'd64});
        end

        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                a_m[i][k] = $urandom();
                b_m[i][k] = $urandom_range(0, 1000);
            end
        load_mats();
        build_expected();
        run_engine("busy", 50, 1);
        compare_results("busy");

        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                a_m[i][k] = $urandom();
                b_m[i][k] = $urandom();
            end
        load_mats();
        @(negedge clk) valid = 1'b1;
        @(negedge clk) valid = 1'b0;
        repeat (59) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("abort_stop", {127'b0, stop}, 128'd0);
        check("abort_state", 128'(dut.state), 128'd0);
        build_expected();
        run_engine("after_abort", 0, 1);
        compare_results("after_abort");

        for (int run = 0; run < 100; run++) begin
            for (int i = 0; i < 8; i++)
                for (int k = 0; k < 8; k++) begin
                    a_m[i][k] = $urandom();
                    b_m[i][k] = $urandom();
                end
            load_mats();
            build_expected();
            run_engine($sformatf("rand%0d", run), 0, 0);
            compare_results($sformatf("rand%0d", run));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end
endmodule
